// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit limit and packed-BCD helpers.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  function automatic logic bcd_nibble_ok(input logic [DIGIT_W-1:0] nib);
    return nib <= DIGIT_MAX;
  endfunction

  // With all nibbles valid, packed-BCD ordering equals plain binary ordering.
  function automatic logic bcd_le(input logic [31:0] a, input logic [31:0] b);
    return a <= b;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with load, forced values and carry/borrow chaining.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               step_in,
  input  logic               up_dn,
  input  logic               force_zero,
  input  logic               force_nine,
  output logic [DIGIT_W-1:0] digit,
  output logic               step_out
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load)
      digit_d = load_digit;
    else if (force_zero)
      digit_d = '0;
    else if (force_nine)
      digit_d = DIGIT_MAX;
    else if (step_in) begin
      if (up_dn)
        digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 4'd1;
      else
        digit_d = (digit_q == '0) ? DIGIT_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      digit_q <= '0;
    else
      digit_q <= digit_d;
  end

  // Carry on 9->0 when counting up, borrow on 0->9 when counting down.
  assign step_out = step_in & (up_dn ? (digit_q == DIGIT_MAX) : (digit_q == '0));
  assign digit    = digit_q;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded up/down BCD counter with validated load, wrap/saturate boundary and tc pulse.
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int unsigned                   NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0]       MAX_VALUE  = 16'h9675,
  parameter bit                            WRAP       = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        up_dn,
  input  logic                        load,
  input  logic [4*NUM_DIGITS-1:0]     load_val,
  output logic [4*NUM_DIGITS-1:0]     count,
  output logic                        tc,
  output logic                        at_max,
  output logic                        at_zero,
  output logic                        load_err
);

  localparam int unsigned W = DIGIT_W * NUM_DIGITS;

  logic              load_valid;
  logic              load_ok;
  logic              cnt_en;
  logic              wrap_up;
  logic              wrap_dn;
  logic [NUM_DIGITS:0] step;
  logic              tc_q, tc_d;
  logic              load_err_q, load_err_d;

  always_comb begin
    load_valid = bcd_le(32'(load_val), 32'(MAX_VALUE));
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      load_valid = load_valid & bcd_nibble_ok(load_val[DIGIT_W*i +: DIGIT_W]);
  end

  assign at_max  = (count == MAX_VALUE);
  assign at_zero = (count == '0);

  // A load request, valid or not, always takes precedence over counting.
  assign load_ok = load & load_valid;
  assign cnt_en  = ena & ~load;
  assign wrap_up = cnt_en & up_dn & at_max;
  assign wrap_dn = cnt_en & ~up_dn & at_zero;
  assign step[0] = cnt_en & ~(up_dn ? at_max : at_zero);

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
    localparam logic [DIGIT_W-1:0] MAX_DIG = MAX_VALUE[DIGIT_W*g +: DIGIT_W];
    // Down-wrap reloads MAX_VALUE: digits 0 and 9 use the force inputs, others the load path.
    localparam bit MAX_MID = (MAX_DIG != '0) && (MAX_DIG != DIGIT_MAX);

    logic               dig_load;
    logic [DIGIT_W-1:0] dig_load_val;
    logic               dig_fz;
    logic               dig_fn;

    assign dig_load     = load_ok | (WRAP & wrap_dn & MAX_MID);
    assign dig_load_val = load_ok ? load_val[DIGIT_W*g +: DIGIT_W] : MAX_DIG;
    assign dig_fz       = WRAP & (wrap_up | (wrap_dn & (MAX_DIG == '0)));
    assign dig_fn       = WRAP & wrap_dn & (MAX_DIG == DIGIT_MAX);

    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (dig_load),
      .load_digit (dig_load_val),
      .step_in    (step[g]),
      .up_dn      (up_dn),
      .force_zero (dig_fz),
      .force_nine (dig_fn),
      .digit      (count[DIGIT_W*g +: DIGIT_W]),
      .step_out   (step[g+1])
    );
  end

  // Top-digit carry cannot occur below MAX_VALUE but is treated as a boundary event.
  always_comb begin
    tc_d       = wrap_up | wrap_dn | step[NUM_DIGITS];
    load_err_d = load & ~load_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign tc       = tc_q;
  assign load_err = load_err_q;

  if (W != 4*NUM_DIGITS) begin : g_bad_width
    $error("digit width mismatch");
  end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed-vector bench for bcd_cascade_counter, wrapping and saturating builds side by side.
module tb_bcd_cascade_counter;

  logic        clk = 1'b0;
  logic        rst, ena, up_dn, load;
  logic [15:0] load_val;
  logic [15:0] count_a, count_b;
  logic        tc_a, tc_b, at_max_a, at_max_b, at_zero_a, at_zero_b, err_a, err_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.NUM_DIGITS(4), .MAX_VALUE(16'h9675), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .ena(ena), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_a), .tc(tc_a), .at_max(at_max_a), .at_zero(at_zero_a), .load_err(err_a)
  );

  bcd_cascade_counter #(.NUM_DIGITS(4), .MAX_VALUE(16'h9675), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .ena(ena), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .at_max(at_max_b), .at_zero(at_zero_b), .load_err(err_b)
  );

  typedef struct {
    logic        rst, load, ena, up;
    logic [15:0] lv;
    logic [15:0] cnt;
    logic        tc, err, amax, azero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic e, input logic u,
                     input logic [15:0] lv, input logic [15:0] c,
                     input logic t, input logic er, input logic am, input logic az);
    vec_t v;
    v.rst = r; v.load = l; v.ena = e; v.up = u; v.lv = lv;
    v.cnt = c; v.tc = t; v.err = er; v.amax = am; v.azero = az;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [15:0] lv);
    @(negedge clk);
    rst = r; load = l; ena = e; up_dn = u; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] c_got, input logic [3:0] f_got,
                       input logic [15:0] c_exp, input logic [3:0] f_exp);
    n_vec++;
    if (c_got !== c_exp || f_got !== f_exp) begin
      n_miss++;
      $display("FAIL %s: count=%h {tc,err,max,zero}=%b, expected count=%h flags=%b",
               name, c_got, f_got, c_exp, f_exp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; ena = 1'b0; up_dn = 1'b1; load_val = '0;

    //   rst load ena up  load_val  count    tc err max zero
    add(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 1, 16'h0455, 16'h0455, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h0456, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h0457, 0, 0, 0, 0);
    add(1, 1, 1, 1, 16'h1111, 16'h0000, 0, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 1, 16'h0999, 16'h0999, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h1000, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      add(0, 0, 1, 1, 16'h0000, 16'h1000 + 16'(i), 0, 0, 0, 0);
    add(0, 1, 0, 1, 16'h9674, 16'h9674, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h9675, 0, 0, 1, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 16'h9675, 1, 0, 1, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h9674, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h9675, 0, 0, 1, 0);
    add(0, 1, 0, 1, 16'h00A0, 16'h9675, 0, 1, 1, 0);
    add(0, 1, 0, 1, 16'h9676, 16'h9675, 0, 1, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 16'h9675, 0, 0, 1, 0);
    add(0, 1, 1, 1, 16'h1234, 16'h1234, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h1233, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'h1000, 16'h1000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0999, 0, 0, 0, 0);
    add(0, 1, 1, 1, 16'h0A00, 16'h0999, 0, 1, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h1000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].ena, vecs[i].up, vecs[i].lv);
      check($sformatf("wrap_vec%0d", i), count_a, {tc_a, err_a, at_max_a, at_zero_a},
            vecs[i].cnt, {vecs[i].tc, vecs[i].err, vecs[i].amax, vecs[i].azero});
    end

    // Saturating build: tc repeats every enabled cycle while pinned at a boundary.
    drive(1, 0, 0, 1, 16'h0000);
    check("sat_reset", count_b, {tc_b, err_b, at_max_b, at_zero_b}, 16'h0000, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 16'h0000);
      check($sformatf("sat_zero_hold%0d", i), count_b, {tc_b, err_b, at_max_b, at_zero_b},
            16'h0000, 4'b1001);
    end
    drive(0, 0, 0, 0, 16'h0000);
    check("sat_zero_idle", count_b, {tc_b, err_b, at_max_b, at_zero_b}, 16'h0000, 4'b0001);
    drive(0, 1, 0, 1, 16'h9674);
    check("sat_load", count_b, {tc_b, err_b, at_max_b, at_zero_b}, 16'h9674, 4'b0000);
    drive(0, 0, 1, 1, 16'h0000);
    check("sat_reach_max", count_b, {tc_b, err_b, at_max_b, at_zero_b}, 16'h9675, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 16'h0000);
      check($sformatf("sat_max_hold%0d", i), count_b, {tc_b, err_b, at_max_b, at_zero_b},
            16'h9675, 4'b1010);
    end
    drive(0, 0, 1, 0, 16'h0000);
    check("sat_turn_down", count_b, {tc_b, err_b, at_max_b, at_zero_b}, 16'h9674, 4'b0000);

    // Reset landing mid-ripple on the wrapping build.
    drive(0, 1, 0, 1, 16'h0999);
    drive(1, 0, 1, 1, 16'h0000);
    check("rst_mid_carry", count_a, {tc_a, err_a, at_max_a, at_zero_a}, 16'h0000, 4'b0001);
    drive(0, 0, 1, 1, 16'h0000);
    check("first_step", count_a, {tc_a, err_a, at_max_a, at_zero_a}, 16'h0001, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
